// File: rtl/block_accumulate_sat.sv
// block_accumulate_sat: sums blocks of signed samples and emits one saturated, narrowed sum per block
// Input and output sides both use valid/ready; a block ends after BLOCK_LEN samples or on flush.
module block_accumulate_sat #(
    parameter int SIZE      = 14,
    parameter int ACC_SIZE  = 20,
    parameter int OUT_SIZE  = 16,
    parameter int BLOCK_LEN = 8,
    localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       sclr,
    input  logic signed [SIZE-1:0]     in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic signed [OUT_SIZE-1:0] out_data,
    output logic                       out_sat,
    output logic [CNT_W-1:0]           out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);
    if (BLOCK_LEN < 1) begin : g_len_check
        $error("BLOCK_LEN must be at least 1");
    end
    if (ACC_SIZE < SIZE + $clog2(BLOCK_LEN)) begin : g_width_check
        $error("ACC_SIZE too narrow to hold a full block sum");
    end

    logic signed [ACC_SIZE-1:0] r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [OUT_SIZE-1:0] r_out_data;
    logic                       r_out_sat;
    logic [CNT_W-1:0]           r_out_count;
    logic                       r_out_valid;

    logic                       w_accept;
    logic                       w_last;
    logic                       w_flush;
    logic                       w_end;
    logic signed [ACC_SIZE-1:0] w_sum;
    logic [CNT_W-1:0]           w_count;
    logic signed [OUT_SIZE-1:0] w_sat_data;
    logic                       w_clip;

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_sum    = r_acc + (w_accept ? ACC_SIZE'(in_data) : '0);
    assign w_count  = r_cnt + CNT_W'(w_accept);
    assign w_last   = w_accept & (r_cnt == CNT_W'(BLOCK_LEN - 1));
    assign w_flush  = flush & in_ready & ((r_cnt != '0) | w_accept);
    assign w_end    = w_last | w_flush;

    // Clipping is needed only when the bits above the output sign bit disagree.
    if (OUT_SIZE >= ACC_SIZE) begin : g_wide
        assign w_sat_data = OUT_SIZE'(w_sum);
        assign w_clip     = 1'b0;
    end else begin : g_narrow
        logic [ACC_SIZE-OUT_SIZE:0] w_top;
        assign w_top      = w_sum[ACC_SIZE-1:OUT_SIZE-1];
        assign w_clip     = ~(&w_top) & (|w_top);
        assign w_sat_data = w_clip ? {w_sum[ACC_SIZE-1], {(OUT_SIZE-1){~w_sum[ACC_SIZE-1]}}}
                                   : w_sum[OUT_SIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else if (w_end) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= w_sat_data;
            r_out_sat   <= w_clip;
            r_out_count <= w_count;
            r_out_valid <= 1'b1;
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= w_count;
            end
            if (out_ready) r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_block_accumulate_sat.sv
// tb_block_accumulate_sat: directed and random checks of the block accumulator against a scoreboard model
module tb_block_accumulate_sat;
    logic               clk = 1'b0;
    logic               sclr = 1'b1;
    logic signed [13:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               flush = 1'b0;
    logic               out_ready = 1'b1;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic [3:0]         out_count;
    logic               out_valid;

    logic signed [13:0] d1_data = '0;
    logic               d1_valid = 1'b0;
    logic               d1_flush = 1'b0;
    logic               d1_oready = 1'b1;
    logic               d1_ready;
    logic signed [15:0] d1_odata;
    logic               d1_sat;
    logic [0:0]         d1_count;
    logic               d1_ovalid;

    typedef struct {int data; bit sat; int count;} res_t;
    res_t q[$];
    int   m_acc = 0;
    int   m_cnt = 0;
    bit   m_ov = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    block_accumulate_sat #(.SIZE(14), .ACC_SIZE(20), .OUT_SIZE(16), .BLOCK_LEN(8)) u_dut (
        .clk(clk), .sclr(sclr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_sat(out_sat), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    block_accumulate_sat #(.SIZE(14), .ACC_SIZE(20), .OUT_SIZE(16), .BLOCK_LEN(1)) u_dut1 (
        .clk(clk), .sclr(sclr), .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
        .flush(d1_flush), .out_data(d1_odata), .out_sat(d1_sat), .out_count(d1_count),
        .out_valid(d1_ovalid), .out_ready(d1_oready)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t make_res(input int s, input int n);
        res_t r;
        r.count = n;
        r.sat   = (s > 32767) || (s < -32768);
        r.data  = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
        return r;
    endfunction

    // Reference model: checks the state left by the last edge, then steps with the inputs for the next edge.
    initial begin : monitor
        bit   rdy, acc;
        int   tot, n;
        res_t r;
        forever begin
            @(negedge clk);
            check("in_ready", in_ready, !m_ov || out_ready);
            check("out_valid", out_valid, m_ov);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("sb_underflow", q.size(), 1);
                else begin
                    r = q.pop_front();
                    check("sb_data", out_data, r.data);
                    check("sb_sat", out_sat, r.sat);
                    check("sb_count", out_count, r.count);
                end
            end
            if (sclr) begin
                m_acc = 0;
                m_cnt = 0;
                m_ov  = 1'b0;
                q.delete();
            end else begin
                rdy = !m_ov || out_ready;
                acc = rdy && in_valid;
                tot = m_acc + (acc ? int'(in_data) : 0);
                n   = m_cnt + int'(acc);
                if ((acc && n == 8) || (flush && rdy && n != 0)) begin
                    q.push_back(make_res(tot, n));
                    m_acc = 0;
                    m_cnt = 0;
                    m_ov  = 1'b1;
                end else begin
                    if (acc) begin
                        m_acc = tot;
                        m_cnt = n;
                    end
                    if (out_ready) m_ov = 1'b0;
                end
            end
        end
    end

    task automatic drive(input int v, input bit valid, input bit fl);
        @(posedge clk);
        #1;
        in_valid = valid;
        in_data  = 14'(v);
        flush    = fl;
    endtask

    task automatic send(input int v, input int n);
        repeat (n) drive(v, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
    endtask

    task automatic block_check(input int v, input int exp_d, input int exp_s);
        send(v, 8);
        check("blk_valid", out_valid, 1);
        check("blk_data", out_data, exp_d);
        check("blk_sat", out_sat, exp_s);
        check("blk_count", out_count, 8);
        drive(0, 1'b0, 1'b0);
        check("blk_pulse", out_valid, 0);
    endtask

    initial begin : stim
        int s[20];
        int v4[3] = '{10, -20, 5};
        repeat (2) @(posedge clk);
        #1 sclr = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", out_sat, 0);
        check("rst_count", out_count, 0);
        check("rst_ready", in_ready, 1);

        block_check(100, 800, 0);
        block_check(8191, 32767, 1);
        block_check(-8192, -32768, 1);
        block_check(4095, 32760, 0);

        out_ready = 1'b0;
        send(1, 8);
        in_valid = 1'b1;
        in_data  = 14'sd7;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_ready", in_ready, 0);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 8);
            check("hold_count", out_count, 8);
        end
        out_ready = 1'b1;
        #1 check("release_ready", in_ready, 1);
        drive(0, 1'b0, 1'b0);
        check("release_consumed", out_valid, 0);
        drive(0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0);
        check("release_data", out_data, 7);
        check("release_count", out_count, 1);

        foreach (v4[i]) drive(v4[i], 1'b1, 1'b0);
        drive(0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0);
        check("flush_valid", out_valid, 1);
        check("flush_data", out_data, -5);
        check("flush_count", out_count, 3);
        drive(0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0);
        check("flush_empty", out_valid, 0);
        drive(0, 1'b0, 1'b0);
        check("flush_empty2", out_valid, 0);

        repeat (5) drive(3, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        sclr = 1'b1;
        @(posedge clk);
        #1 sclr = 1'b0;
        check("sclr_valid", out_valid, 0);
        check("sclr_data", out_data, 0);
        check("sclr_sat", out_sat, 0);
        check("sclr_count", out_count, 0);
        block_check(1, 8, 0);

        for (int i = 0; i < 20; i++) begin
            s[i] = int'($urandom_range(0, 16383)) - 8192;
            @(posedge clk);
            #1;
            d1_valid = 1'b1;
            d1_data  = 14'(s[i]);
            if (i > 0) begin
                check("len1_valid", d1_ovalid, 1);
                check("len1_data", d1_odata, s[i-1]);
                check("len1_count", d1_count, 1);
                check("len1_ready", d1_ready, 1);
            end
        end
        @(posedge clk);
        #1 d1_valid = 1'b0;
        check("len1_last", d1_odata, s[19]);
        @(posedge clk);
        #1 check("len1_idle", d1_ovalid, 0);

        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            case ($urandom_range(0, 3))
                0: in_data = 14'sd8191;
                1: in_data = -14'sd8192;
                default: in_data = 14'($urandom);
            endcase
            in_valid  = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 9) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            sclr      = $urandom_range(0, 999) == 0;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        sclr      = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
